seg7_scan_mux: RTL and testbench
================================

Name: seg7_scan_mux

Overview:
- Parametrised, time-multiplexed driver for an N-digit common-anode 7-segment display.
- Latches a packed nibble value on a load strobe and scans one digit at a time.
- Decodes each digit to active-low segments in decimal or hex mode, with leading-zero blanking, per-digit decimal points and whole-display blink.
- Sits between datapath/status logic and the board display pins.

Parameters:
- N_DIGITS, 4, number of digits scanned; legal range 2..8.
- SCAN_DIV, 50000, clock cycles per digit slot; must be >= 2.
- BLINK_FRAMES, 64, full scan frames per blink half-period; must be >= 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  when high at a clk edge, capture value and dp_in.
- value  in  4*N_DIGITS  packed nibbles; value[3:0] is digit 0 (least significant, rightmost).
- dp_in  in  N_DIGITS  decimal-point request per digit, active-high.
- hex_mode  in  1  1 = decode 0-F; 0 = decimal, nibbles 10-15 blank.
- lz_blank  in  1  1 = suppress leading zeros.
- blink_en  in  1  1 = blink the whole display.
- seg  out  7  segments, active-low; seg[0]=a, seg[1]=b, seg[2]=c, seg[3]=d, seg[4]=e, seg[5]=f, seg[6]=g.
- dp  out  1  decimal point, active-low.
- an  out  N_DIGITS  digit anode enables, active-low, one-hot-low when showing.
- frame_tick  out  1  one-cycle pulse when the last digit slot ends.

Behaviour:
- Reset (synchronous, priority over everything):
  - seg=7'h7F, dp=1, an=all 1s, frame_tick=0.
  - Captured value and dp cleared to 0; digit index=0; divider=0; blink frame counter=0; blink phase=visible; FSM to BLANK.
  - Reset asserted mid-slot aborts the slot; outputs are off on the cycle after the reset edge.
- Capture: a load edge registers value/dp_in. The new data drives the outputs from the next output register update. There is no handshake; load may be held high, which recaptures every cycle.
- FSM, two states per digit slot:
  - BLANK: exactly 1 cycle. an=all 1s, seg=7'h7F, dp=1 (anti-ghosting).
  - SHOW: SCAN_DIV-1 cycles. an[idx]=0, all others 1; seg/dp as decoded for digit idx.
  - At the end of SHOW: idx increments, wrapping N_DIGITS-1 -> 0, then go to BLANK.
  - frame_tick=1 for the single cycle in which idx wraps to 0.
  - Slot period is exactly SCAN_DIV cycles; frame period is N_DIGITS*SCAN_DIV.
- Outputs are registered. seg/dp/an reflect the state, idx and captured data of the previous cycle, giving 1-cycle latency.
- Decode table (active-low, g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000
  - hex only: A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - decimal mode with nibble >9: seg=7'h7F; dp still honoured.
- Leading-zero blanking:
  - With lz_blank=1, digit i>0 is blanked (seg=7'h7F) when nibbles N_DIGITS-1 down to i are all zero.
  - Digit 0 is never blanked.
  - A blanked digit's dp is still shown if requested.
  - In decimal mode, an invalid nibble (>9) is nonzero and stops blanking.
- Blink:
  - The blink frame counter counts frame_ticks while blink_en=1; every BLINK_FRAMES ticks the phase toggles.
  - Hidden phase: an=all 1s; scanning continues.
  - blink_en=0: synchronously clears the counter and forces phase=visible on the next edge.
- Simultaneous events:
  - rst beats load.
  - load on the same edge as a slot change: the new data is used for the new slot.
  - Mode inputs (hex_mode, lz_blank) are not captured; they take effect combinationally into the next output register update.

Test Plan (SCAN_DIV=4, N_DIGITS=4, BLINK_FRAMES=2):
- Reset -> first cycle after reset: seg=7F, an=F, dp=1. Release reset, load value=16'h0000 -> BLANK then SHOW sequence an=F,E,E,E,F,D,D,D,F,B,... with frame_tick pulse once per 16 cycles.
- hex_mode=1, load 16'hA5C9 -> an=E seg=0011000; an=D seg=1000110; an=B seg=0010010; an=7 seg=0001000.
- hex_mode=0, load 16'h00B3, lz_blank=1 -> digit0 seg=0110000, digit1 (B) seg=7F, digits 3 and 2 blanked. Same with lz_blank=0 -> digits 3 and 2 show 1000000.
- dp_in=4'b0100, load 16'h0000, lz_blank=1 -> digit2 seg=7F with dp=0; all other digits dp=1; digit0 seg=1000000.
- blink_en=1 -> an visible for 2 frames (32 cycles), all 1s for 2 frames, repeating. Deassert mid-hidden -> an resumes scanning within 2 cycles.
- Load during SHOW of digit1 -> seg changes the cycle after the load edge. Assert rst mid-slot -> next cycle seg=7F, an=F, captured value=0, scan restarts at digit0 with BLANK.

Source files
------------

// File: rtl/seg7_scan_mux_if.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_mux_if
//  Description : Bundle between the datapath/status logic (master) and the
//                7-segment scan driver (slave): load strobe, packed digit
//                nibbles, decimal points, display modes and the display pins.
//  Revision    : 1.0 - initial release
// ============================================================================
interface seg7_scan_mux_if #(
    parameter int N_DIGITS = 4
);
    logic                    load;
    logic [4*N_DIGITS-1:0]   value;
    logic [N_DIGITS-1:0]     dp_in;
    logic                    hex_mode;
    logic                    lz_blank;
    logic                    blink_en;
    logic [6:0]              seg;
    logic                    dp;
    logic [N_DIGITS-1:0]     an;
    logic                    frame_tick;

    modport master (
        output load, value, dp_in, hex_mode, lz_blank, blink_en,
        input  seg, dp, an, frame_tick
    );

    modport slave (
        input  load, value, dp_in, hex_mode, lz_blank, blink_en,
        output seg, dp, an, frame_tick
    );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_mux
//  Description : Time-multiplexed N-digit common-anode 7-segment driver.
//                Captures packed nibbles on load, scans one digit per slot
//                (1 blank cycle + SCAN_DIV-1 show cycles), decodes decimal or
//                hex with leading-zero blanking, per-digit dp and blink.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_mux #(
    parameter int N_DIGITS     = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  wire logic        clk,
    input  wire logic        rst,
    seg7_scan_mux_if.slave   io_disp
);
    localparam int IDX_W   = $clog2(N_DIGITS);
    localparam int DIV_W   = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);

    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(N_DIGITS - 1);
    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
    localparam logic [6:0]         SEG_OFF    = 7'h7F;

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

    logic [0:0]              r_state;
    logic [0:0]              w_state_next;
    logic [DIV_W-1:0]        r_div;
    logic [DIV_W-1:0]        w_div_next;
    logic [IDX_W-1:0]        r_idx;
    logic [IDX_W-1:0]        w_idx_next;
    logic                    w_wrap;

    logic [4*N_DIGITS-1:0]   r_value;
    logic [N_DIGITS-1:0]     r_dp_cap;
    logic [BLINK_W-1:0]      r_blink_cnt;
    logic                    r_hidden;

    logic [N_DIGITS-1:0]     w_upper_zero;
    logic                    w_zero_run;
    logic [3:0]              w_nib;
    logic [6:0]              w_glyph;
    logic                    w_valid;
    logic                    w_lz_hide;
    logic [6:0]              w_seg_next;
    logic                    w_dp_next;
    logic [N_DIGITS-1:0]     w_an_next;

    logic [6:0]              r_seg;
    logic                    r_dp_out;
    logic [N_DIGITS-1:0]     r_an;
    logic                    r_frame_tick;

    // Scan FSM state, slot divider and digit index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_BLANK;
            r_div   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_div   <= w_div_next;
            r_idx   <= w_idx_next;
        end
    end

    // Next state: one BLANK cycle, then SHOW until the slot divider expires.
    always_comb begin
        w_state_next = r_state;
        w_div_next   = r_div;
        w_idx_next   = r_idx;
        w_wrap       = 1'b0;
        case (r_state)
            ST_BLANK: begin
                w_state_next = ST_SHOW;
                w_div_next   = DIV_W'(1);
            end
            ST_SHOW: begin
                if (r_div == DIV_LAST) begin
                    w_state_next = ST_BLANK;
                    w_div_next   = '0;
                    if (r_idx == IDX_LAST) begin
                        w_idx_next = '0;
                        w_wrap     = 1'b1;
                    end else begin
                        w_idx_next = r_idx + IDX_W'(1);
                    end
                end else begin
                    w_div_next = r_div + DIV_W'(1);
                end
            end
            default: w_state_next = ST_BLANK;
        endcase
    end

    // Capture displayed data; reset wins over a simultaneous load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_value  <= '0;
            r_dp_cap <= '0;
        end else if (io_disp.load) begin
            r_value  <= io_disp.value;
            r_dp_cap <= io_disp.dp_in;
        end
    end

    // Blink phase: toggles every BLINK_FRAMES frame wraps while enabled.
    always_ff @(posedge clk) begin
        if (rst || !io_disp.blink_en) begin
            r_blink_cnt <= '0;
            r_hidden    <= 1'b0;
        end else if (w_wrap) begin
            if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt <= '0;
                r_hidden    <= ~r_hidden;
            end else begin
                r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
            end
        end
    end

    // Leading-zero map: bit i set when nibbles N_DIGITS-1 down to i are zero.
    always_comb begin
        w_zero_run   = 1'b1;
        w_upper_zero = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            w_zero_run      = w_zero_run && (r_value[4*i +: 4] == 4'h0);
            w_upper_zero[i] = w_zero_run;
        end
    end

    // Output decode for the current state/digit; mode inputs act live.
    always_comb begin
        w_nib      = r_value[{r_idx, 2'b00} +: 4];
        w_glyph    = SEG_OFF;
        case (w_nib)
            4'h0: w_glyph = 7'h40;
            4'h1: w_glyph = 7'h79;
            4'h2: w_glyph = 7'h24;
            4'h3: w_glyph = 7'h30;
            4'h4: w_glyph = 7'h19;
            4'h5: w_glyph = 7'h12;
            4'h6: w_glyph = 7'h02;
            4'h7: w_glyph = 7'h78;
            4'h8: w_glyph = 7'h00;
            4'h9: w_glyph = 7'h18;
            4'hA: w_glyph = 7'h08;
            4'hB: w_glyph = 7'h03;
            4'hC: w_glyph = 7'h46;
            4'hD: w_glyph = 7'h21;
            4'hE: w_glyph = 7'h06;
            4'hF: w_glyph = 7'h0E;
            default: w_glyph = SEG_OFF;
        endcase
        w_valid    = io_disp.hex_mode || (w_nib <= 4'd9);
        // Digit 0 always shows so a zero value still reads "0".
        w_lz_hide  = io_disp.lz_blank && (r_idx != '0) && w_upper_zero[r_idx];
        w_seg_next = SEG_OFF;
        w_dp_next  = 1'b1;
        w_an_next  = '1;
        if (r_state == ST_SHOW) begin
            w_seg_next = (w_valid && !w_lz_hide) ? w_glyph : SEG_OFF;
            w_dp_next  = ~r_dp_cap[r_idx];
            if (!r_hidden) begin
                for (int i = 0; i < N_DIGITS; i++) begin
                    w_an_next[i] = (r_idx != IDX_W'(i));
                end
            end
        end
    end

    // Registered display pins; frame_tick marks the cycle idx has wrapped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg        <= SEG_OFF;
            r_dp_out     <= 1'b1;
            r_an         <= '1;
            r_frame_tick <= 1'b0;
        end else begin
            r_seg        <= w_seg_next;
            r_dp_out     <= w_dp_next;
            r_an         <= w_an_next;
            r_frame_tick <= w_wrap;
        end
    end

    assign io_disp.seg        = r_seg;
    assign io_disp.dp         = r_dp_out;
    assign io_disp.an         = r_an;
    assign io_disp.frame_tick = r_frame_tick;
endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_mux
//  Description : Directed self-checking bench for seg7_scan_mux with
//                N_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_mux;
    localparam int ND = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    logic [6:0] cap_seg [4];
    logic       cap_dp  [4];
    logic [3:0] cap_an  [4];

    always #5 clk = ~clk;

    seg7_scan_mux_if #(.N_DIGITS(ND)) bus ();

    seg7_scan_mux #(
        .N_DIGITS    (ND),
        .SCAN_DIV    (4),
        .BLINK_FRAMES(2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_disp(bus)
    );

    // Waits (bounded) until a negedge where frame_tick is high.
    task automatic sync_frame();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (bus.frame_tick === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL sync_frame: frame_tick=%b, required 1 within 40 cycles", bus.frame_tick);
        end
    endtask

    // Called in a frame_tick cycle: loads data, records each digit's outputs.
    task automatic grab_frame(input logic [15:0] v, input logic [3:0] dpi);
        bus.value = v;
        bus.dp_in = dpi;
        bus.load  = 1'b1;
        @(negedge clk);
        bus.load  = 1'b0;
        for (int d = 0; d < 4; d++) begin
            @(negedge clk);
            cap_seg[d] = bus.seg;
            cap_dp[d]  = bus.dp;
            cap_an[d]  = bus.an;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.load = 1'b1; bus.value = 16'h1234; bus.dp_in = 4'hF;
        bus.hex_mode = 1'b0; bus.lz_blank = 1'b0; bus.blink_en = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.seg !== 7'h7F) begin failures++; $display("FAIL reset_seg: got %h required 7f", bus.seg); end
        checks++; if (bus.an !== 4'hF) begin failures++; $display("FAIL reset_an: got %h required f", bus.an); end
        checks++; if (bus.dp !== 1'b1) begin failures++; $display("FAIL reset_dp: got %b required 1", bus.dp); end
        checks++; if (bus.frame_tick !== 1'b0) begin failures++; $display("FAIL reset_tick: got %b required 0", bus.frame_tick); end
    endtask

    task automatic test_scan_sequence();
        logic [3:0] exp_an [16];
        exp_an = '{4'hF,4'hE,4'hE,4'hE,4'hF,4'hD,4'hD,4'hD,4'hF,4'hB,4'hB,4'hB,4'hF,4'h7,4'h7,4'h7};
        rst = 1'b0; bus.load = 1'b0; bus.value = 16'h0000; bus.dp_in = 4'h0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            checks++;
            if (bus.an !== exp_an[k % 16]) begin failures++; $display("FAIL scan_an[%0d]: got %h required %h", k, bus.an, exp_an[k % 16]); end
            checks++;
            if (bus.frame_tick !== (k % 16 == 15)) begin failures++; $display("FAIL scan_tick[%0d]: got %b required %b", k, bus.frame_tick, (k % 16 == 15)); end
            if (k == 1) begin
                checks++;
                if (bus.seg !== 7'h40) begin failures++; $display("FAIL rst_beats_load_seg: got %h required 40", bus.seg); end
            end
        end
    endtask

    task automatic test_hex_decode();
        logic [6:0] exp_seg [4];
        logic [3:0] exp_an  [4];
        exp_an = '{4'hE, 4'hD, 4'hB, 4'h7};
        bus.hex_mode = 1'b1; bus.lz_blank = 1'b0;
        sync_frame(); grab_frame(16'hA5C9, 4'h0);
        exp_seg = '{7'h18, 7'h46, 7'h12, 7'h08};
        for (int d = 0; d < 4; d++) begin
            checks++; if (cap_seg[d] !== exp_seg[d]) begin failures++; $display("FAIL hexA5C9_seg[%0d]: got %h required %h", d, cap_seg[d], exp_seg[d]); end
            checks++; if (cap_an[d] !== exp_an[d]) begin failures++; $display("FAIL hexA5C9_an[%0d]: got %h required %h", d, cap_an[d], exp_an[d]); end
            checks++; if (cap_dp[d] !== 1'b1) begin failures++; $display("FAIL hexA5C9_dp[%0d]: got %b required 1", d, cap_dp[d]); end
        end
        sync_frame(); grab_frame(16'hFEDB, 4'h0);
        exp_seg = '{7'h03, 7'h21, 7'h06, 7'h0E};
        for (int d = 0; d < 4; d++) begin
            checks++; if (cap_seg[d] !== exp_seg[d]) begin failures++; $display("FAIL hexFEDB_seg[%0d]: got %h required %h", d, cap_seg[d], exp_seg[d]); end
        end
    endtask

    task automatic test_decimal_lz();
        logic [6:0] exp_seg [4];
        bus.hex_mode = 1'b0; bus.lz_blank = 1'b1;
        sync_frame(); grab_frame(16'h00B3, 4'h0);
        exp_seg = '{7'h30, 7'h7F, 7'h7F, 7'h7F};
        for (int d = 0; d < 4; d++) begin
            checks++; if (cap_seg[d] !== exp_seg[d]) begin failures++; $display("FAIL dec_lz1_seg[%0d]: got %h required %h", d, cap_seg[d], exp_seg[d]); end
        end
        bus.lz_blank = 1'b0;
        sync_frame(); grab_frame(16'h00B3, 4'h0);
        exp_seg = '{7'h30, 7'h7F, 7'h40, 7'h40};
        for (int d = 0; d < 4; d++) begin
            checks++; if (cap_seg[d] !== exp_seg[d]) begin failures++; $display("FAIL dec_lz0_seg[%0d]: got %h required %h", d, cap_seg[d], exp_seg[d]); end
        end
        sync_frame(); grab_frame(16'h8764, 4'h0);
        exp_seg = '{7'h19, 7'h02, 7'h78, 7'h00};
        for (int d = 0; d < 4; d++) begin
            checks++; if (cap_seg[d] !== exp_seg[d]) begin failures++; $display("FAIL dec8764_seg[%0d]: got %h required %h", d, cap_seg[d], exp_seg[d]); end
        end
        bus.lz_blank = 1'b1;
        sync_frame(); grab_frame(16'h0021, 4'h0);
        exp_seg = '{7'h79, 7'h24, 7'h7F, 7'h7F};
        for (int d = 0; d < 4; d++) begin
            checks++; if (cap_seg[d] !== exp_seg[d]) begin failures++; $display("FAIL dec0021_seg[%0d]: got %h required %h", d, cap_seg[d], exp_seg[d]); end
        end
    endtask

    task automatic test_dp();
        logic [6:0] exp_seg [4];
        logic       exp_dp  [4];
        bus.hex_mode = 1'b0; bus.lz_blank = 1'b1;
        sync_frame(); grab_frame(16'h0000, 4'b0100);
        exp_seg = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
        exp_dp  = '{1'b1, 1'b1, 1'b0, 1'b1};
        for (int d = 0; d < 4; d++) begin
            checks++; if (cap_seg[d] !== exp_seg[d]) begin failures++; $display("FAIL dp_seg[%0d]: got %h required %h", d, cap_seg[d], exp_seg[d]); end
            checks++; if (cap_dp[d] !== exp_dp[d]) begin failures++; $display("FAIL dp_dp[%0d]: got %b required %b", d, cap_dp[d], exp_dp[d]); end
        end
    endtask

    task automatic test_load_midslot_and_reset();
        bus.hex_mode = 1'b0; bus.lz_blank = 1'b0; bus.dp_in = 4'h0;
        sync_frame();
        bus.value = 16'h0000; bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (bus.an !== 4'hD || bus.seg !== 7'h40) begin failures++; $display("FAIL mid_before: an=%h seg=%h required an=d seg=40", bus.an, bus.seg); end
        bus.value = 16'h0050; bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        checks++; if (bus.seg !== 7'h40) begin failures++; $display("FAIL mid_load_edge_seg: got %h required 40", bus.seg); end
        @(negedge clk);
        checks++; if (bus.seg !== 7'h12 || bus.an !== 4'hD) begin failures++; $display("FAIL mid_after_seg: seg=%h an=%h required seg=12 an=d", bus.seg, bus.an); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (bus.seg !== 7'h7F || bus.an !== 4'hF || bus.dp !== 1'b1) begin failures++; $display("FAIL midrst_off: seg=%h an=%h dp=%b required 7f f 1", bus.seg, bus.an, bus.dp); end
        @(negedge clk);
        checks++; if (bus.an !== 4'hF) begin failures++; $display("FAIL midrst_blank: an=%h required f", bus.an); end
        @(negedge clk);
        checks++; if (bus.an !== 4'hE || bus.seg !== 7'h40) begin failures++; $display("FAIL midrst_digit0: an=%h seg=%h required e 40", bus.an, bus.seg); end
    endtask

    task automatic test_blink();
        int n_off;
        int n_on;
        sync_frame();
        bus.blink_en = 1'b1;
        sync_frame();
        sync_frame();
        checks++; if (bus.an !== 4'h7) begin failures++; $display("FAIL blink_edge_an: got %h required 7", bus.an); end
        n_off = 0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (bus.an === 4'hF) n_off++;
        end
        checks++; if (n_off != 32) begin failures++; $display("FAIL blink_hidden: off cycles=%0d required 32", n_off); end
        n_on = 0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (bus.an !== 4'hF) n_on++;
        end
        checks++; if (n_on != 24) begin failures++; $display("FAIL blink_visible: lit cycles=%0d required 24", n_on); end
        repeat (8) @(negedge clk);
        checks++; if (bus.an !== 4'hF) begin failures++; $display("FAIL blink_rehidden: an=%h required f", bus.an); end
        bus.blink_en = 1'b0;
        @(negedge clk);
        checks++; if (bus.an !== 4'hF) begin failures++; $display("FAIL blink_off_1: an=%h required f", bus.an); end
        @(negedge clk);
        checks++; if (bus.an !== 4'hB) begin failures++; $display("FAIL blink_off_2: an=%h required b", bus.an); end
    endtask

    initial begin
        test_reset();
        test_scan_sequence();
        test_hex_decode();
        test_decimal_lz();
        test_dp();
        test_load_midslot_and_reset();
        test_blink();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
